// File: rtl/sd_px_unpack_if.sv
// Interfaces for sd_px_unpack.
//   sd_stream_if : word stream from the SD interface (master = SD side).
//   sd_px_if     : pixel stream toward the display writer (master = unpacker).
interface sd_stream_if;
    logic [31:0] stream_data;
    logic        stream_trigger;
    logic        stream_busy;

    modport master (output stream_data, stream_trigger, input stream_busy);
    modport slave  (input stream_data, stream_trigger, output stream_busy);
endinterface

interface sd_px_if #(
    parameter int X_W = 9,
    parameter int Y_W = 8
);
    logic [15:0]    px_data;
    logic           px_valid;
    logic           px_ready;
    logic [X_W-1:0] px_x;
    logic [Y_W-1:0] px_y;
    logic           px_sof;
    logic           px_eol;

    modport master (output px_data, px_valid, px_x, px_y, px_sof, px_eol,
                    input  px_ready);
    modport slave  (input  px_data, px_valid, px_x, px_y, px_sof, px_eol,
                    output px_ready);
endinterface

// File: rtl/sd_px_unpack.sv
// sd_px_unpack: unpacks each 32-bit SD stream word into two RGB565 pixels
// ([31:16] first) and presents them on a valid/ready port with raster x/y,
// start-of-frame / end-of-line flags, a frame_done pulse and a sticky
// overflow flag for words offered while a previous word is still held.
// Optional build macro: BYTE_SWAP_EN -- byte-swap each 16-bit pixel
// (little-endian raw images). Undefined: pixels pass unchanged.
module sd_px_unpack #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int X_W   = 9,
    parameter int Y_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_rst,
    sd_stream_if.slave        stream,
    sd_px_if.master           px,
    output logic              frame_done,
    output logic              ovf_err
);

    typedef enum logic [1:0] {IDLE, PX_HI, PX_LO} state_t;

    state_t      state;
    logic        trig_d;
    logic [15:0] lo_half_r;   // second pixel of the held word
    logic        trig_edge;
    logic        handshake;
    logic        last_x;
    logic        last_y;

    // Pixel byte order applied on the way out.
    function automatic logic [15:0] fmt_px(input logic [15:0] p);
`ifdef BYTE_SWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    assign trig_edge  = stream.stream_trigger & ~trig_d;
    assign handshake  = px.px_valid & px.px_ready;
    assign last_x     = (px.px_x == X_W'(H_RES - 1));
    assign last_y     = (px.px_y == Y_W'(V_RES - 1));
    assign px.px_sof  = (px.px_x == '0) && (px.px_y == '0);
    assign px.px_eol  = last_x;

    // Trigger level history for rising-edge detection; one word per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_d <= 1'b0;
        else        trig_d <= stream.stream_trigger;
    end

    // Word FSM: capture on edge, hand out high then low pixel, flag lost words.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would make the result order-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            lo_half_r          <= '0;
            px.px_data         <= '0;
            px.px_valid        <= 1'b0;
            stream.stream_busy <= 1'b0;
            ovf_err            <= 1'b0;
        end else if (frame_rst) begin
            // Realign: drop any held word and a same-cycle edge, clear overflow.
            state              <= IDLE;
            px.px_valid        <= 1'b0;
            stream.stream_busy <= 1'b0;
            ovf_err            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        lo_half_r          <= stream.stream_data[15:0];
                        px.px_data         <= fmt_px(stream.stream_data[31:16]);
                        px.px_valid        <= 1'b1;
                        stream.stream_busy <= 1'b1;
                        state              <= PX_HI;
                    end
                end
                PX_HI: begin
                    if (trig_edge) ovf_err <= 1'b1;
                    if (px.px_ready) begin
                        px.px_data <= fmt_px(lo_half_r);
                        state      <= PX_LO;
                    end
                end
                PX_LO: begin
                    if (trig_edge) ovf_err <= 1'b1;
                    if (px.px_ready) begin
                        px.px_valid        <= 1'b0;
                        stream.stream_busy <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: begin
                    state              <= IDLE;
                    px.px_valid        <= 1'b0;
                    stream.stream_busy <= 1'b0;
                end
            endcase
        end
    end

    // Raster position: advance on every accepted pixel, pulse frame_done
    // after the last pixel of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px.px_x    <= '0;
            px.px_y    <= '0;
            frame_done <= 1'b0;
        end else if (frame_rst) begin
            px.px_x    <= '0;
            px.px_y    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (handshake) begin
                if (last_x) begin
                    px.px_x    <= '0;
                    px.px_y    <= last_y ? '0 : px.px_y + Y_W'(1);
                    frame_done <= last_y;
                end else begin
                    px.px_x <= px.px_x + X_W'(1);
                end
            end
        end
    end

endmodule
